// File: rtl/xor_mismatch_counter_pkg.sv
// Shared types and helpers for the xor/xnor mismatch checker.
package xor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_v) ? max_v : value + 32'd1;
    endfunction

endpackage

// File: rtl/xor_mismatch_counter_if.sv
// Sample/control/result bundle between a frame controller and the checker.
interface xor_mismatch_counter_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic             y1;
    logic             y2;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] match_count;
    logic             inv_fault;
    logic             fail;

    modport master (
        output start, in_valid, y1, y2,
        input  busy, done, err_count, match_count, inv_fault, fail
    );

    modport slave (
        input  start, in_valid, y1, y2,
        output busy, done, err_count, match_count, inv_fault, fail
    );
endinterface

// File: rtl/xor_mismatch_counter_sat_counter.sv
// CNT_W-bit saturating up-counter with synchronous clear and enable.
module sat_counter
    import xor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over enable; increments stop at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/xor_mismatch_counter.sv
// Frame-based mismatch/match counter for the xor_xnor gate outputs with
// complementary-output check and pass/fail verdict.
module xor_mismatch_counter
    import xor_pkg::*;
#(
    parameter int          FRAME_LEN  = 16,
    parameter int          CNT_W      = 8,
    parameter int unsigned ERR_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    xor_mismatch_counter_if.slave  bus
);
    localparam int SMP_W = $clog2(FRAME_LEN + 1);
    localparam logic [SMP_W-1:0] LAST_IDX = SMP_W'(FRAME_LEN - 1);

    state_e           state_d, state_q;
    logic [SMP_W-1:0] smp_d, smp_q;
    logic             inv_d, inv_q;
    logic             fail_d, fail_q;
    logic             done_d, done_q;
    logic             clr;
    logic             acc;
    logic             mism;
    logic             mtch;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_fin;

    // A sample is only taken while counting; y1==y2 samples bump neither count.
    assign acc  = (state_q == COUNT) && bus.in_valid;
    assign mism = acc &&  bus.y1 && !bus.y2;
    assign mtch = acc && !bus.y1 &&  bus.y2;

    // Next-state, sample counter, sticky fault and verdict.
    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        inv_d   = inv_q;
        fail_d  = fail_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        // The verdict must include the sample accepted on the final edge.
        err_fin = mism ? CNT_W'(sat_inc(32'(err_cnt), CNT_W)) : err_cnt;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = COUNT;
                    clr     = 1'b1;
                    smp_d   = '0;
                    inv_d   = 1'b0;
                    fail_d  = 1'b0;
                end
            end
            COUNT: begin
                if (bus.in_valid) begin
                    smp_d = smp_q + SMP_W'(1);
                    if (bus.y1 == bus.y2) inv_d = 1'b1;
                    if (smp_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        fail_d  = (32'(err_fin) >= ERR_THRESH) || inv_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            smp_q   <= '0;
            inv_q   <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            inv_q   <= inv_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (mism),
        .cnt (err_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (mtch),
        .cnt (match_cnt)
    );

    assign bus.busy        = (state_q == COUNT);
    assign bus.done        = done_q;
    assign bus.inv_fault   = inv_q;
    assign bus.fail        = fail_q;
    assign bus.err_count   = err_cnt;
    assign bus.match_count = match_cnt;
endmodule

// File: tb/tb_xor_mismatch_counter.sv
// Scoreboard bench for xor_mismatch_counter: frame stimulus pushes expected
// verdicts, a negedge monitor pops and compares on each done pulse.
module tb_xor_mismatch_counter;
    localparam int FL = 16;
    localparam int CW = 8;
    localparam int TH = 2;

    typedef struct {
        int err;
        int match;
        int inv;
        int fail;
        int eqn;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   prev_done = 0;
    exp_t sb[$];
    exp_t last_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xor_mismatch_counter_if #(.CNT_W(CW)) bus ();

    xor_mismatch_counter #(
        .FRAME_LEN (FL),
        .CNT_W     (CW),
        .ERR_THRESH(TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 0;
        end else begin
            if (bus.done) begin
                chk("done_width", prev_done, 0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending frame (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_latency", cyc, e.cyc);
                    chk("err_count", int'(bus.err_count), e.err);
                    chk("match_count", int'(bus.match_count), e.match);
                    chk("inv_fault", int'(bus.inv_fault), e.inv);
                    chk("fail", int'(bus.fail), e.fail);
                    chk("busy_at_done", int'(bus.busy), 0);
                    chk("count_sum", int'(bus.err_count) + int'(bus.match_count) + e.eqn, FL);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_timeout: got no done expected at cycle %0d (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            prev_done = int'(bus.done);
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        adv();
        bus.start = 1'b0;
    endtask

    // Drives one frame of FL valid samples with optional idle gaps; the
    // expected outcome is derived straight from the counting rules.
    task automatic send_samples(input bit [FL-1:0] y1v, input bit [FL-1:0] y2v,
                                input int gap_max, input bit start_mid);
        exp_t e;
        e = '{err: 0, match: 0, inv: 0, fail: 0, eqn: 0, cyc: 0};
        for (int i = 0; i < FL; i++) begin
            if (y1v[i] && !y2v[i]) e.err++;
            else if (!y1v[i] && y2v[i]) e.match++;
            else e.eqn++;
        end
        e.inv  = (e.eqn > 0) ? 1 : 0;
        e.fail = (e.err >= TH || e.inv != 0) ? 1 : 0;
        for (int i = 0; i < FL; i++) begin
            int g;
            g = int'($urandom_range(gap_max, 0));
            for (int k = 0; k < g; k++) begin
                bus.in_valid = 1'b0;
                bus.y1 = 1'($urandom);
                bus.y2 = 1'($urandom);
                adv();
            end
            bus.in_valid = 1'b1;
            bus.y1 = y1v[i];
            bus.y2 = y2v[i];
            bus.start = (start_mid && i == 3);
            if (i == FL - 1) begin
                e.cyc = cyc + 1;
                sb.push_back(e);
                last_exp = e;
            end
            adv();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    // Idle cycles with noisy in_valid; results of the last frame must hold.
    task automatic tail(input int n);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'($urandom);
            bus.y1 = 1'($urandom);
            bus.y2 = 1'($urandom);
            adv();
        end
        bus.in_valid = 1'b0;
        chk("hold_err", int'(bus.err_count), last_exp.err);
        chk("hold_match", int'(bus.match_count), last_exp.match);
        chk("hold_fail", int'(bus.fail), last_exp.fail);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_err"}, int'(bus.err_count), 0);
        chk({nm, "_match"}, int'(bus.match_count), 0);
        chk({nm, "_inv"}, int'(bus.inv_fault), 0);
        chk({nm, "_fail"}, int'(bus.fail), 0);
    endtask

    task automatic rand_frame(output bit [FL-1:0] y1v, output bit [FL-1:0] y2v, input int fault_pct);
        for (int i = 0; i < FL; i++) begin
            bit a, b;
            a = 1'($urandom);
            b = 1'($urandom);
            y1v[i] = a ^ b;
            y2v[i] = ~(a ^ b);
            if (int'($urandom_range(99, 0)) < fault_pct) begin
                y1v[i] = 1'($urandom);
                y2v[i] = y1v[i];
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [FL-1:0] y1v, y2v, tt1, tt2;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.y1 = 1'b0;
        bus.y2 = 1'b0;
        last_exp = '{err: 0, match: 0, inv: 0, fail: 0, eqn: 0, cyc: 0};
        adv();
        adv();
        rst = 1'b0;
        check_zero("reset");
        tail(3);

        // Clean frame: a==b throughout.
        start_pulse();
        send_samples({FL{1'b0}}, {FL{1'b1}}, 0, 1'b0);
        tail(3);

        // Truth-table cycle 00,01,10,11.
        for (int i = 0; i < FL; i++) begin
            tt1[i] = ((i % 4) == 1) || ((i % 4) == 2);
            tt2[i] = ~tt1[i];
        end
        start_pulse();
        send_samples(tt1, tt2, 0, 1'b0);
        tail(2);

        // Exactly one mismatch stays under threshold.
        y1v = '0;
        y1v[7] = 1'b1;
        start_pulse();
        send_samples(y1v, ~y1v, 0, 1'b0);
        tail(2);

        // Truth table again with gaps.
        start_pulse();
        send_samples(tt1, tt2, 3, 1'b0);
        tail(2);

        // Invariant fault on sample 5.
        y1v = '0;
        y2v = '1;
        y1v[4] = 1'b1;
        start_pulse();
        send_samples(y1v, y2v, 1, 1'b0);
        tail(2);

        // start during COUNT is ignored.
        rand_frame(y1v, y2v, 0);
        start_pulse();
        send_samples(y1v, y2v, 2, 1'b1);
        tail(2);

        // Restart in the done cycle.
        rand_frame(y1v, y2v, 0);
        start_pulse();
        send_samples(y1v, y2v, 0, 1'b0);
        start_pulse();
        chk("restart_busy", int'(bus.busy), 1);
        chk("restart_err", int'(bus.err_count), 0);
        chk("restart_match", int'(bus.match_count), 0);
        chk("restart_done", int'(bus.done), 0);
        rand_frame(y1v, y2v, 10);
        send_samples(y1v, y2v, 2, 1'b0);
        tail(3);

        // Reset mid-frame: no done, everything cleared.
        start_pulse();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.y1 = 1'b1;
            bus.y2 = 1'b0;
            adv();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        adv();
        adv();
        check_zero("midreset");
        rst = 1'b0;
        last_exp = '{err: 0, match: 0, inv: 0, fail: 0, eqn: 0, cyc: 0};
        tail(FL + 4);

        // Random frames.
        for (int f = 0; f < 8; f++) begin
            rand_frame(y1v, y2v, 8);
            start_pulse();
            send_samples(y1v, y2v, int'($urandom_range(3, 0)), 1'($urandom));
            tail(int'($urandom_range(4, 1)));
        end

        tail(4);
        chk("scoreboard_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/xor_mismatch_counter.md
Name: xor_mismatch_counter

Overview:
Downstream consumer of the xor_xnor gate. Samples the gate's y1 (XOR, mismatch) and y2 (XNOR, match) outputs once per valid strobe over a fixed-length frame. Accumulates mismatch and match counts, checks the complementary-output invariant, and reports a pass/fail verdict against a threshold. Used as a bit-compare checker, for example BER-style comparison of two serial streams driven onto the gate's a and b inputs.

Parameters:
FRAME_LEN, 16, number of valid samples per frame (>=1)
CNT_W, 8, counter width; must satisfy 2^CNT_W-1 >= FRAME_LEN
ERR_THRESH, 2, frame fails when the mismatch count is >= ERR_THRESH

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame; ignored unless in IDLE or DONE
in_valid  in  1  y1/y2 sample qualifier
y1  in  1  XOR output of xor_xnor (1 = mismatch)
y2  in  1  XNOR output of xor_xnor (1 = match)
busy  out  1  high while in COUNT
done  out  1  one-cycle pulse when a frame completes
err_count  out  CNT_W  mismatches in the last or current frame
match_count  out  CNT_W  matches in the last or current frame
inv_fault  out  1  sticky: some sample in the frame had y1==y2
fail  out  1  verdict, valid from done onward: (err_count>=ERR_THRESH) or inv_fault

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE. busy, done, fail and inv_fault are 0. err_count and match_count are 0. Internal sample counter is 0. rst has priority over every other input.
- States: IDLE, COUNT, DONE.
- IDLE:
  - start=1 -> COUNT. Clear err_count, match_count, inv_fault, fail and the sample counter.
  - in_valid is ignored.
- COUNT (busy=1):
  - Each cycle with in_valid=1, sample counter += 1.
  - If y1=1 and y2=0: err_count += 1.
  - If y1=0 and y2=1: match_count += 1.
  - If y1==y2: inv_fault <= 1 and neither count increments; the sample still counts toward FRAME_LEN.
  - in_valid=0 cycles do nothing.
  - start is ignored in COUNT; a frame is never restarted mid-flight.
- COUNT -> DONE: on the cycle the FRAME_LEN-th valid sample is accepted. Counts include that final sample. fail is computed from the final counts and registered in the same edge. done=1 for exactly the first cycle in DONE.
- DONE:
  - Counts, inv_fault and fail hold their values.
  - start=1 -> COUNT with the same clearing as from IDLE, and done=0 in that cycle.
  - Otherwise the block stays in DONE with done=0 after the first cycle.
- Latency: done is asserted on the cycle immediately after the edge that accepts the last sample. Back-to-back valid samples give done FRAME_LEN+1 cycles after the start cycle.
- Count width: CNT_W unsigned. Counters saturate at all-ones and never wrap. The parameter constraint makes saturation unreachable in legal configs, but it is still implemented.
- Invariant: err_count + match_count + (number of y1==y2 samples) == FRAME_LEN at done.
- FRAME_LEN=1: a single valid sample goes straight to DONE.
- ERR_THRESH=0: fail is always 1 at done.
- Reset mid-frame: rst during COUNT returns to IDLE, clears all outputs, and produces no done pulse.

Decomposition:
- Shared package xor_pkg holds:
  - state enum type: IDLE=2'd0, COUNT=2'd1, DONE=2'd2
  - function sat_inc(value, width)
- One natural sub-module, sat_counter: a CNT_W-bit saturating counter with sync clear and enable. It is instantiated twice (err and match). The sample counter is a plain counter inside the top.

Test Plan:
- Reset: hold rst 2 cycles mid-frame -> state IDLE, err_count=0, match_count=0, busy=0, no done pulse.
- Clean frame: start, then 16 back-to-back valid samples with a=b, so y1=0 and y2=1 -> done exactly 17 cycles after start, match_count=16, err_count=0, fail=0, inv_fault=0.
- Threshold: 16 samples cycling through the gate truth table (a,b = 00,01,10,11 repeated) -> err_count=8, match_count=8, fail=1 with ERR_THRESH=2. A separate frame with exactly 1 mismatch -> fail=0.
- Gapped valid: 16 valid samples interleaved with random in_valid=0 cycles where y1/y2 toggle -> counts are identical to the gap-free run, and done comes 1 cycle after the 16th valid.
- Invariant fault: force y1=y2=1 on sample 5 -> inv_fault=1, fail=1, err_count+match_count=15 at done.
- Restart and ignore: pulse start during COUNT -> ignored and the frame completes normally. Pulse start in the done cycle -> new frame begins, counts clear next cycle, done is not repeated.
